count_seq_ctrl: RTL and testbench

- Sequencer for the programmable 7-bit count path plus BCD conversion.
- Accepts a start request with a target value and steps an internal 7-bit counter from 0 to the target at a prescaled rate.
- On reaching the target, runs a sequential double-dabble binary-to-BCD conversion, then presents the two BCD digits on a valid/ready handshake.
- Sits between control logic (switches/buttons or host FSM) and the display drivers.

---
 rtl/count_seq_ctrl_pkg.sv | 20 ++
 rtl/count_seq_ctrl_if.sv | 25 ++
 rtl/count_seq_ctrl_bin2bcd.sv | 55 +++++
 rtl/count_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_count_seq_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and sizes for the count sequencer and its BCD converter.
package count_seq_pkg;

  localparam int CNT_W   = 7;
  localparam int BCD_W   = 4;
  localparam int DD_ITER = 7;
  localparam int SR_W    = 2 * BCD_W + CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, CONV, DONE} state_e;

  // One double-dabble iteration: bias nibbles >= 5 by 3, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    if (t[SR_W-BCD_W-1 -: BCD_W] >= 4'd5) t[SR_W-BCD_W-1 -: BCD_W] = t[SR_W-BCD_W-1 -: BCD_W] + 4'd3;
    if (t[SR_W-1 -: BCD_W] >= 4'd5) t[SR_W-1 -: BCD_W] = t[SR_W-1 -: BCD_W] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Control/result bundle between a host (master) and the count sequencer (slave).
interface count_seq_ctrl_if;
  import count_seq_pkg::*;

  logic             start;
  logic [CNT_W-1:0] max_count;
  logic             abort;
  logic             bcd_ready;
  logic             busy;
  logic [CNT_W-1:0] count_out;
  logic [BCD_W-1:0] bcd_tens;
  logic [BCD_W-1:0] bcd_ones;
  logic             bcd_valid;

  modport master (
    output start, max_count, abort, bcd_ready,
    input  busy, count_out, bcd_tens, bcd_ones, bcd_valid
  );

  modport slave (
    input  start, max_count, abort, bcd_ready,
    output busy, count_out, bcd_tens, bcd_ones, bcd_valid
  );

endinterface

// File: rtl/count_seq_ctrl_bin2bcd.sv
// Sequential double-dabble: load a 7-bit value, done pulses with the digits
// on the 7th iteration cycle so the caller can register them on that edge.
module bin2bcd_seq_7
  import count_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [SR_W-1:0] shift_q, shift_d, shift_next;
  logic [2:0]      iter_q, iter_d;
  logic            active_q, active_d;

  // A new load restarts the unit, so a stale run can never raise done.
  always_comb begin
    shift_next = dd_step(shift_q);
    shift_d    = shift_q;
    iter_d     = iter_q;
    active_d   = active_q;
    done       = 1'b0;
    if (load) begin
      shift_d  = {{(2*BCD_W){1'b0}}, value};
      iter_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      shift_d = shift_next;
      iter_d  = iter_q + 3'd1;
      if (iter_q == 3'(DD_ITER - 1)) begin
        active_d = 1'b0;
        done     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      iter_q   <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      iter_q   <= iter_d;
      active_q <= active_d;
    end
  end

  assign tens = shift_next[SR_W-1 -: BCD_W];
  assign ones = shift_next[SR_W-BCD_W-1 -: BCD_W];

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencer: counts 0..target at a prescaled rate, converts to BCD, hands off.
// COUNT_SEQ_AUTO_RESTART_EN: after the handshake, restart counting instead of idling.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int MAX_LIMIT = 99
) (
  input logic             CLK,
  input logic             RST_N,
  count_seq_ctrl_if.slave bus
);

  localparam logic [7:0]       PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(MAX_LIMIT);

  state_e           state_q, state_d;
  logic [7:0]       presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             valid_q, valid_d;
  logic             load_q, load_d;
  logic             dd_done;
  logic [BCD_W-1:0] dd_tens, dd_ones;

  // load_q marks the first CONV cycle, when the converter captures count_q.
  bin2bcd_seq_7 u_bin2bcd (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (load_q),
    .value (count_q),
    .done  (dd_done),
    .tens  (dd_tens),
    .ones  (dd_ones)
  );

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    target_d = target_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    valid_d  = valid_q;
    load_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            target_d = (bus.max_count > LIMIT) ? LIMIT : bus.max_count;
            count_d  = '0;
            presc_d  = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (count_q == target_q) begin
            state_d = CONV;
            load_d  = 1'b1;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q + CNT_W'(1);
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        CONV: begin
          if (dd_done) begin
            tens_d  = dd_tens;
            ones_d  = dd_ones;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (valid_q && bus.bcd_ready) begin
            valid_d = 1'b0;
`ifdef COUNT_SEQ_AUTO_RESTART_EN
            count_d = '0;
            presc_d = '0;
            state_d = RUN;
`else
            state_d = IDLE;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_q  <= '0;
      target_q <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      valid_q  <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      target_q <= target_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      valid_q  <= valid_d;
      load_q   <= load_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.count_out = count_q;
  assign bus.bcd_tens  = tens_q;
  assign bus.bcd_ones  = ones_q;
  assign bus.bcd_valid = valid_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: DUT index 0 runs with TICK_DIV=1, index 1 with TICK_DIV=4.
// Expected digits are queued at start and popped when bcd_valid is presented.
module tb_count_seq_ctrl;
  import count_seq_pkg::*;

  typedef struct {
    int tens;
    int ones;
    int cnt;
  } exp_t;

`ifdef COUNT_SEQ_AUTO_RESTART_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic             CLK   = 1'b0;
  logic             RST_N = 1'b0;
  logic [1:0]       start_v = '0;
  logic [1:0]       abort_v = '0;
  logic [1:0]       ready_v = '0;
  logic [CNT_W-1:0] maxc_v  [2];
  logic [1:0]       busy_o, valid_o;
  logic [CNT_W-1:0] count_o [2];
  logic [BCD_W-1:0] tens_o  [2];
  logic [BCD_W-1:0] ones_o  [2];
  exp_t             sb_q [$];
  int               total = 0;
  int               bad   = 0;

  count_seq_ctrl_if bus1 ();
  count_seq_ctrl_if bus4 ();

  assign bus1.start     = start_v[0];
  assign bus1.abort     = abort_v[0];
  assign bus1.bcd_ready = ready_v[0];
  assign bus1.max_count = maxc_v[0];
  assign bus4.start     = start_v[1];
  assign bus4.abort     = abort_v[1];
  assign bus4.bcd_ready = ready_v[1];
  assign bus4.max_count = maxc_v[1];

  assign busy_o     = {bus4.busy, bus1.busy};
  assign valid_o    = {bus4.bcd_valid, bus1.bcd_valid};
  assign count_o[0] = bus1.count_out;
  assign count_o[1] = bus4.count_out;
  assign tens_o[0]  = bus1.bcd_tens;
  assign tens_o[1]  = bus4.bcd_tens;
  assign ones_o[0]  = bus1.bcd_ones;
  assign ones_o[1]  = bus4.bcd_ones;

  count_seq_ctrl #(.TICK_DIV(1), .MAX_LIMIT(99)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1.slave)
  );

  count_seq_ctrl #(.TICK_DIV(4), .MAX_LIMIT(99)) u_dut4 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus4.slave)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushExp(input int tgt);
    exp_t e;
    e.tens = tgt / 10;
    e.ones = tgt % 10;
    e.cnt  = tgt;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle (n=0).
  task automatic applyStimulus(input int sel, input int maxc, output int tgt);
    tgt = (maxc > 99) ? 99 : maxc;
    pushExp(tgt);
    maxc_v[sel]  = CNT_W'(maxc);
    start_v[sel] = 1'b1;
    @(negedge CLK);
    start_v[sel] = 1'b0;
  endtask

  // n counts RUN/CONV cycles since the accepting edge; valid is due 9 after count hits target.
  task automatic checkRun(input int sel, input int tgt, input int n_start, input int n_end);
    int td;
    int exp_cnt;
    td = (sel != 0) ? 4 : 1;
    for (int n = n_start; n <= n_end; n++) begin
      if (n != n_start) @(negedge CLK);
      exp_cnt = (n / td < tgt) ? n / td : tgt;
      checkOutput("run_busy", int'(busy_o[sel]), 1);
      checkOutput("run_count", int'(count_o[sel]), exp_cnt);
      checkOutput("run_valid", int'(valid_o[sel]), (n >= tgt * td + 9) ? 1 : 0);
    end
  endtask

  task automatic getResult(input int sel, input int hold);
    exp_t e;
    e = sb_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h != 0) @(negedge CLK);
      checkOutput("hold_valid", int'(valid_o[sel]), 1);
      checkOutput("bcd_tens", int'(tens_o[sel]), e.tens);
      checkOutput("bcd_ones", int'(ones_o[sel]), e.ones);
      checkOutput("final_count", int'(count_o[sel]), e.cnt);
    end
    ready_v[sel] = 1'b1;
    @(negedge CLK);
    ready_v[sel] = 1'b0;
    checkOutput("post_hs_valid", int'(valid_o[sel]), 0);
    checkOutput("post_hs_busy", int'(busy_o[sel]), AUTO);
    checkOutput("post_hs_count", int'(count_o[sel]), (AUTO != 0) ? 0 : e.cnt);
    checkOutput("post_hs_tens", int'(tens_o[sel]), e.tens);
  endtask

  initial begin
    int tgt;
    maxc_v[0] = '0;
    maxc_v[1] = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_busy", int'(busy_o[0]), 0);
    checkOutput("rst_count", int'(count_o[0]), 0);
    checkOutput("rst_tens", int'(tens_o[0]), 0);
    checkOutput("rst_ones", int'(ones_o[0]), 0);
    checkOutput("rst_valid", int'(valid_o[0]), 0);
    RST_N = 1'b1;
    @(negedge CLK);

`ifdef COUNT_SEQ_AUTO_RESTART_EN
    $display("[TB] auto-restart build");
    applyStimulus(0, 3, tgt);
    checkRun(0, tgt, 0, tgt + 9);
    getResult(0, 2);
    for (int r = 0; r < 2; r++) begin
      pushExp(tgt);
      checkRun(0, tgt, 0, tgt + 9);
      getResult(0, 0);
    end
    abort_v[0] = 1'b1;
    @(negedge CLK);
    abort_v[0] = 1'b0;
    checkOutput("auto_abort_busy", int'(busy_o[0]), 0);
    checkOutput("auto_abort_valid", int'(valid_o[0]), 0);
    sb_q.delete();
`else
    $display("[TB] target 0");
    applyStimulus(0, 0, tgt);
    checkRun(0, tgt, 0, 9);
    getResult(0, 0);

    $display("[TB] target 5, TICK_DIV=1");
    applyStimulus(0, 5, tgt);
    checkRun(0, tgt, 0, tgt + 9);
    getResult(0, 0);

    $display("[TB] target 120 clamps to 99");
    applyStimulus(0, 120, tgt);
    checkRun(0, tgt, 0, tgt + 9);
    getResult(0, 1);

    $display("[TB] target 37, TICK_DIV=4, ready withheld");
    applyStimulus(1, 37, tgt);
    checkRun(1, tgt, 0, tgt * 4 + 9);
    getResult(1, 10);

    $display("[TB] abort at count 20 with target 50");
    applyStimulus(0, 50, tgt);
    checkRun(0, tgt, 0, 10);
    start_v[0] = 1'b1;
    maxc_v[0]  = 7'd3;
    @(negedge CLK);
    start_v[0] = 1'b0;
    maxc_v[0]  = 7'd0;
    checkRun(0, tgt, 11, 20);
    abort_v[0] = 1'b1;
    @(negedge CLK);
    abort_v[0] = 1'b0;
    checkOutput("abort_busy", int'(busy_o[0]), 0);
    checkOutput("abort_count", int'(count_o[0]), 20);
    checkOutput("abort_valid", int'(valid_o[0]), 0);
    sb_q.delete();
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    maxc_v[0]  = 7'd9;
    @(negedge CLK);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    checkOutput("abort_start_busy", int'(busy_o[0]), 0);
    checkOutput("abort_start_count", int'(count_o[0]), 20);
    @(negedge CLK);
    checkOutput("abort_start_idle", int'(busy_o[0]), 0);

    $display("[TB] reset during conversion");
    applyStimulus(0, 12, tgt);
    checkRun(0, tgt, 0, tgt + 3);
    RST_N = 1'b0;
    #1;
    checkOutput("arst_busy", int'(busy_o[0]), 0);
    checkOutput("arst_count", int'(count_o[0]), 0);
    checkOutput("arst_tens", int'(tens_o[0]), 0);
    checkOutput("arst_ones", int'(ones_o[0]), 0);
    checkOutput("arst_valid", int'(valid_o[0]), 0);
    checkOutput("arst_tens_dut4", int'(tens_o[1]), 0);
    checkOutput("arst_ones_dut4", int'(ones_o[1]), 0);
    sb_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    $display("[TB] recovery run, target 42");
    applyStimulus(0, 42, tgt);
    checkRun(0, tgt, 0, tgt + 9);
    getResult(0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
